fp_add_arbiter: RTL and testbench

- Shares one pipelined FP16 adder (fixed latency, no valid/stall inputs) among NUM_REQ requesters.
- Round-robin issue of at most one operand pair per cycle.
- Tags each operation through a shift pipeline aligned to the adder latency, and steers each sum back to the requester that issued it through a per-requester response register with valid/ready handshake.
- Each requester may have at most one outstanding operation.

---
 rtl/fp_add_arbiter.sv | 139 +++++++++++++
 tb/tb_fp_add_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP16 adder among NUM_REQ
// requesters, with a tag pipeline steering each sum back to its issuer.
module fp_add_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADD_LAT = 4,
  parameter int unsigned TAG_W   = 2
) (
  input  logic                    clock_80,
  input  logic                    reset_80,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_op_a,
  input  logic [16*NUM_REQ-1:0]   req_op_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [16*NUM_REQ-1:0]   rsp_sum,
  output logic [15:0]             add_in_1,
  output logic [15:0]             add_in_2,
  input  logic [15:0]             add_sum,
  output logic [3:0]              inflight,
  output logic                    busy
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LAST   = ADD_LAT;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
  } tag_t;

  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] rsp_done;
  logic [NUM_REQ-1:0] capture_hot;
  logic [NUM_REQ-1:0] rsp_valid_nxt;
  logic [TAG_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]   grant_idx;
  logic [TAG_W-1:0]   cand_idx;
  logic               grant_found;
  int unsigned        cand;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic [CNT_W-1:0]   inflight_nxt;
  tag_t               tag_pipe [0:LAST];
  tag_t               tag_last;

  // Round-robin search from rr_ptr over requesters without an outstanding op
  always_comb begin
    eligible    = req_valid & ~pending;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = TAG_W'(cand);
      if (!grant_found && eligible[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    req_ready = '0;
    if (grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Operand mux driven by the one-hot grant
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_a = req_op_a[i*DATA_W +: DATA_W];
        sel_b = req_op_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state for response valids and the in-flight count
  always_comb begin
    tag_last    = tag_pipe[LAST];
    rsp_done    = rsp_valid & rsp_ready;
    capture_hot = '0;
    if (tag_last.vld) begin
      capture_hot[tag_last.tag] = 1'b1;
    end
    rsp_valid_nxt = (rsp_valid & ~rsp_done) | capture_hot;
    inflight_nxt  = inflight + CNT_W'(grant_found) - CNT_W'(tag_last.vld);
  end

  // Issue, tag shift, response capture and bookkeeping registers
  always_ff @(posedge clock_80 or posedge reset_80) begin
    if (reset_80) begin
      add_in_1  <= '0;
      add_in_2  <= '0;
      rsp_valid <= '0;
      rsp_sum   <= '0;
      pending   <= '0;
      rr_ptr    <= '0;
      inflight  <= '0;
      busy      <= 1'b0;
      for (int unsigned k = 0; k <= LAST; k++) begin
        tag_pipe[k] <= '0;
      end
    end else begin
      add_in_1 <= grant_found ? sel_a : '0;
      add_in_2 <= grant_found ? sel_b : '0;
      pending  <= (pending & ~rsp_done) | req_ready;
      if (grant_found) begin
        rr_ptr <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
      end
      tag_pipe[0] <= '{vld: grant_found, tag: grant_idx};
      for (int unsigned k = 1; k <= LAST; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (capture_hot[i]) begin
          rsp_sum[i*DATA_W +: DATA_W] <= add_sum;
        end
      end
      rsp_valid <= rsp_valid_nxt;
      inflight  <= inflight_nxt;
      busy      <= (inflight_nxt != '0) || (|rsp_valid_nxt);
    end
  end

  // A capture must never land on a response the requester has not yet taken
  capture_no_overwrite: assert property (
    @(posedge clock_80) disable iff (reset_80)
    tag_last.vld |-> !rsp_valid[tag_last.tag]
  );

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter using an integer-add stub as the adder.
module tb_fp_add_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADD_LAT = 4;
  localparam int unsigned TAG_W   = 2;

  logic                  clock_80 = 1'b0;
  logic                  reset_80 = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_op_a = '0;
  logic [16*NUM_REQ-1:0] req_op_b = '0;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready = '1;
  logic [16*NUM_REQ-1:0] rsp_sum;
  logic [15:0]           add_in_1;
  logic [15:0]           add_in_2;
  logic [15:0]           add_sum;
  logic [3:0]            inflight;
  logic                  busy;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] t2_sum [4] = '{16'h0001, 16'h0101, 16'h0201, 16'h0301};

  always #5 clock_80 = ~clock_80;

  fp_add_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADD_LAT(ADD_LAT),
    .TAG_W  (TAG_W)
  ) dut (
    .clock_80 (clock_80),
    .reset_80 (reset_80),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op_a (req_op_a),
    .req_op_b (req_op_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_sum  (rsp_sum),
    .add_in_1 (add_in_1),
    .add_in_2 (add_in_2),
    .add_sum  (add_sum),
    .inflight (inflight),
    .busy     (busy)
  );

  // Stub adder: ADD_LAT-deep pipeline of the integer sum, no reset
  logic [15:0] stub_pipe [ADD_LAT];
  always_ff @(posedge clock_80) begin
    stub_pipe[0] <= add_in_1 + add_in_2;
    for (int k = 1; k < int'(ADD_LAT); k++) begin
      stub_pipe[k] <= stub_pipe[k-1];
    end
  end
  assign add_sum = stub_pipe[ADD_LAT-1];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_op_a[i*16 +: 16] = a;
    req_op_b[i*16 +: 16] = b;
  endtask

  function automatic logic [15:0] sum_of(input int i);
    return rsp_sum[i*16 +: 16];
  endfunction

  task automatic end_cyc();
    @(posedge clock_80);
    #1;
  endtask

  // Leaves the bench at 1 ns after an edge, in cycle 1 after reset
  task automatic do_reset();
    reset_80  = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    req_op_a  = '0;
    req_op_b  = '0;
    repeat (2) @(posedge clock_80);
    #1;
    reset_80 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values and a single operation
    do_reset();
    check_val("rst_add_in_1", 32'(add_in_1), 32'h0);
    check_val("rst_add_in_2", 32'(add_in_2), 32'h0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_val("rst_rsp_sum", 32'(rsp_sum[31:0]), 32'h0);
    check_val("rst_inflight", 32'(inflight), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    for (int c = 1; c <= 8; c++) begin
      req_valid = (c == 1) ? 4'b0001 : 4'b0000;
      if (c == 1) set_op(0, 16'h3C00, 16'h0001);
      #2;
      if (c == 1) check_val("t1_ready", 32'(req_ready), 32'h1);
      if (c == 2) begin
        check_val("t1_add_in_1", 32'(add_in_1), 32'h3C00);
        check_val("t1_add_in_2", 32'(add_in_2), 32'h0001);
        check_val("t1_inflight", 32'(inflight), 32'h1);
      end
      if (c >= 2 && c <= 6) check_val($sformatf("t1_no_rsp_c%0d", c), 32'(rsp_valid), 32'h0);
      if (c == 7) begin
        check_val("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        check_val("t1_rsp_sum", 32'(sum_of(0)), 32'h3C01);
        check_val("t1_busy", 32'(busy), 32'h1);
      end
      if (c == 8) begin
        check_val("t1_rsp_clear", 32'(rsp_valid), 32'h0);
        check_val("t1_idle", 32'(busy), 32'h0);
        check_val("t1_inflight_0", 32'(inflight), 32'h0);
      end
      end_cyc();
    end

    // All four requesters at once
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 16'(16'h0100 * i), 16'h0001);
    for (int c = 1; c <= 10; c++) begin
      req_valid = (c <= 4) ? 4'(4'b1111 << (c - 1)) : 4'b0000;
      #2;
      if (c <= 4) check_val($sformatf("t2_ready_c%0d", c), 32'(req_ready), 32'(1 << (c - 1)));
      if (c == 5) check_val("t2_inflight_peak", 32'(inflight), 32'h4);
      if (c >= 7) begin
        check_val($sformatf("t2_rsp_valid_c%0d", c), 32'(rsp_valid), 32'(1 << (c - 7)));
        check_val($sformatf("t2_rsp_sum_c%0d", c), 32'(sum_of(c - 7)), 32'(t2_sum[c - 7]));
      end
      end_cyc();
    end

    // Backpressure on requester 2
    do_reset();
    rsp_ready = 4'b1011;
    set_op(2, 16'h1234, 16'h0011);
    req_valid = 4'b0100;
    for (int c = 1; c <= 28; c++) begin
      if (c == 21) rsp_ready = '1;
      if (c == 22) set_op(2, 16'h2000, 16'h0002);
      if (c == 23) req_valid = '0;
      #2;
      check_val($sformatf("t3_ready_c%0d", c), 32'(req_ready),
                (c == 1 || c == 22) ? 32'h4 : 32'h0);
      if (c >= 7 && c <= 21) begin
        check_val($sformatf("t3_hold_valid_c%0d", c), 32'(rsp_valid), 32'h4);
        check_val($sformatf("t3_hold_sum_c%0d", c), 32'(sum_of(2)), 32'h1245);
      end
      if (c == 22) check_val("t3_rsp_clear", 32'(rsp_valid), 32'h0);
      if (c == 28) begin
        check_val("t3_rsp2_valid", 32'(rsp_valid), 32'h4);
        check_val("t3_rsp2_sum", 32'(sum_of(2)), 32'h2002);
      end
      end_cyc();
    end

    // Fairness between requesters 1 and 3
    do_reset();
    set_op(1, 16'h0010, 16'h0005);
    set_op(3, 16'h0300, 16'h0030);
    req_valid = 4'b1010;
    for (int c = 1; c <= 16; c++) begin
      logic [31:0] exp_ready;
      #2;
      exp_ready = 32'h0;
      if (c == 1 || c == 8 || c == 15) exp_ready = 32'h2;
      if (c == 2 || c == 9 || c == 16) exp_ready = 32'h8;
      check_val($sformatf("t4_ready_c%0d", c), 32'(req_ready), exp_ready);
      if (c == 7) begin
        check_val("t4_rsp1_valid", 32'(rsp_valid), 32'h2);
        check_val("t4_rsp1_sum", 32'(sum_of(1)), 32'h0015);
      end
      if (c == 8) begin
        check_val("t4_rsp3_valid", 32'(rsp_valid), 32'h8);
        check_val("t4_rsp3_sum", 32'(sum_of(3)), 32'h0330);
      end
      end_cyc();
    end

    // Asynchronous reset with three operations in flight
    do_reset();
    set_op(0, 16'h0A00, 16'h0100);
    set_op(1, 16'h0A01, 16'h0100);
    set_op(2, 16'h0A02, 16'h0100);
    for (int c = 1; c <= 4; c++) begin
      req_valid = (c <= 3) ? 4'(4'(4'b0111 << (c - 1)) & 4'b0111) : 4'b0000;
      #2;
      if (c <= 3) check_val($sformatf("t5_ready_c%0d", c), 32'(req_ready), 32'(1 << (c - 1)));
      end_cyc();
    end
    req_valid = '0;
    #2;
    check_val("t5_inflight_pre", 32'(inflight), 32'h3);
    check_val("t5_busy_pre", 32'(busy), 32'h1);
    reset_80 = 1'b1;
    #1;
    check_val("t5_inflight_rst", 32'(inflight), 32'h0);
    check_val("t5_busy_rst", 32'(busy), 32'h0);
    check_val("t5_rsp_valid_rst", 32'(rsp_valid), 32'h0);
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      #2;
      check_val($sformatf("t5_quiet_c%0d", c), 32'(rsp_valid), 32'h0);
      end_cyc();
    end
    set_op(1, 16'h4000, 16'h0003);
    for (int c = 1; c <= 7; c++) begin
      req_valid = (c == 1) ? 4'b0010 : 4'b0000;
      #2;
      if (c == 1) check_val("t5_new_ready", 32'(req_ready), 32'h2);
      if (c >= 2 && c <= 6) check_val($sformatf("t5_new_wait_c%0d", c), 32'(rsp_valid), 32'h0);
      if (c == 7) begin
        check_val("t5_new_valid", 32'(rsp_valid), 32'h2);
        check_val("t5_new_sum", 32'(sum_of(1)), 32'h4003);
      end
      end_cyc();
    end

    // Same-cycle response handshake and new request on requester 0
    do_reset();
    rsp_ready = 4'b1110;
    set_op(0, 16'h0500, 16'h0005);
    req_valid = 4'b0001;
    for (int c = 1; c <= 15; c++) begin
      if (c == 8) begin
        rsp_ready = '1;
        set_op(0, 16'h0600, 16'h0006);
      end
      if (c == 10) req_valid = '0;
      #2;
      if (c == 1) check_val("t6_ready_first", 32'(req_ready), 32'h1);
      if (c == 7) begin
        check_val("t6_rsp1_valid", 32'(rsp_valid), 32'h1);
        check_val("t6_rsp1_sum", 32'(sum_of(0)), 32'h0505);
      end
      if (c == 8) begin
        check_val("t6_ready_same_cycle", 32'(req_ready), 32'h0);
        check_val("t6_rsp1_still_valid", 32'(rsp_valid), 32'h1);
      end
      if (c == 9) begin
        check_val("t6_ready_regrant", 32'(req_ready), 32'h1);
        check_val("t6_rsp1_clear", 32'(rsp_valid), 32'h0);
      end
      if (c == 15) begin
        check_val("t6_rsp2_valid", 32'(rsp_valid), 32'h1);
        check_val("t6_rsp2_sum", 32'(sum_of(0)), 32'h0606);
      end
      end_cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
